// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem req/ack, small (pc, word) FIFO towards decode.
// Optional misaligned-redirect trap selected by `define IF_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter int unsigned   N        = 32,
    parameter logic [N-1:0]  RESET_PC = '0,
    parameter int unsigned   DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic [N-1:0] Instruction,
    output logic [N-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic         fetch_fault
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD, HALT} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    pc_q, pc_d;
    logic [N-1:0]    addr_q, addr_d;
    logic            req_q, req_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic            halt_pend_q, halt_pend_d;
    logic [N-1:0]    buf_pc   [DEPTH];
    logic [N-1:0]    buf_data [DEPTH];
    logic            push, pop, misalign, redir_take;
    logic [N-1:0]    target;

    assign target = redirect_pc & ~(N'(3));

`ifdef IF_MISALIGN_TRAP_EN
    assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // In HALT only an aligned redirect is honoured.
    assign redir_take = redirect_valid && ((state_q != HALT) || !misalign);

    // Next-state, buffer bookkeeping and redirect handling.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        fault_d     = fault_q;
        halt_pend_d = halt_pend_q;
        push        = (state_q == FETCH) && imem_ack && !redirect_valid;
        pop         = valid_q && instr_ready && !redirect_valid;
        if (push) wr_d = wr_q + PW'(1);
        if (pop)  rd_d = rd_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);

        case (state_q)
            IDLE: begin
                if (count_q < CW'(DEPTH)) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    pc_d    = pc_q + N'(4);
                    state_d = (count_d < CW'(DEPTH)) ? FETCH : IDLE;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_d     = halt_pend_q ? HALT : IDLE;
                    halt_pend_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (redir_take) begin
            count_d     = '0;
            rd_d        = '0;
            wr_d        = '0;
            pc_d        = target;
            fault_d     = misalign;
            halt_pend_d = 1'b0;
            case (state_q)
                FETCH, DISCARD: begin
                    if (imem_ack) begin
                        state_d = misalign ? HALT : IDLE;
                    end else begin
                        state_d     = DISCARD;
                        halt_pend_d = misalign;
                    end
                end
                default: state_d = misalign ? HALT : IDLE;
            endcase
        end

        // The in-flight address stays on the bus while draining a discarded fetch.
        addr_d  = (state_d == DISCARD) ? addr_q : pc_d;
        req_d   = (state_d == FETCH) || (state_d == DISCARD);
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            count_q     <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            halt_pend_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_pc[PW'(i)]   <= '0;
                buf_data[PW'(i)] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
            halt_pend_q <= halt_pend_d;
            if (push) begin
                buf_pc[wr_q]   <= addr_q;
                buf_data[wr_q] <= imem_rdata;
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign Instruction = buf_data[rd_q];
    assign instr_pc    = buf_pc[rd_q];
    assign fetch_fault = fault_q;

endmodule
